// File: rtl/cpu_sequencer.sv
// Instruction-phase sequencer for a small CPU: steps IDLE/FETCH/EXEC/MEM/WB,
// handles single-step, one hardware breakpoint, memory-ack timeout and the retire counter.
module cpu_sequencer #(
    parameter int PC_W    = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_pi,
    input  logic             reset_pi,
    input  logic             clk_en_pi,
    input  logic             run_mode_pi,
    input  logic             step_pi,
    input  logic             halt_cmd_pi,
    input  logic             load_pi,
    input  logic             store_pi,
    input  logic             mem_ack_pi,
    input  logic [PC_W-1:0]  pc_pi,
    input  logic [PC_W-1:0]  bkpt_addr_pi,
    input  logic             bkpt_en_pi,
    output logic             fetch_en_po,
    output logic             commit_po,
    output logic             mem_req_po,
    output logic             halted_po,
    output logic             fault_po,
    output logic             bkpt_hit_po,
    output logic [2:0]       state_po,
    output logic [CNT_W-1:0] instr_count_po
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             bkpt_hit_q, bkpt_hit_d;
    logic             step_pend_q, step_pend_d;
    logic             skip_bkpt_q, skip_bkpt_d;
    logic             step_prev_q;
    logic [7:0]       wait_cnt_q, wait_cnt_d;

    logic             step_edge;
    logic             bkpt_match;
    logic [7:0]       wait_inc;
    logic             fetch_en;
    logic             commit;
    logic             mem_req;

    always_comb begin
        step_edge     = step_pi & ~step_prev_q;
        // skip_bkpt lets the instruction sitting on the breakpoint execute once after a step
        bkpt_match    = bkpt_en_pi && (pc_pi == bkpt_addr_pi) && !skip_bkpt_q;
        wait_inc      = wait_cnt_q + 8'd1;

        state_d       = state_q;
        instr_count_d = instr_count_q;
        bkpt_hit_d    = bkpt_hit_q;
        step_pend_d   = step_pend_q | ((state_q == S_IDLE) & step_edge);
        skip_bkpt_d   = skip_bkpt_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_en      = 1'b0;
        commit        = 1'b0;
        mem_req       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clk_en_pi) begin
                    if (step_pend_q) begin
                        state_d     = S_FETCH;
                        step_pend_d = 1'b0;
                        bkpt_hit_d  = 1'b0;
                        skip_bkpt_d = 1'b1;
                    end else if (run_mode_pi && !bkpt_hit_q) begin
                        state_d     = S_FETCH;
                        step_pend_d = 1'b0;
                    end
                end
            end
            S_FETCH: begin
                if (clk_en_pi) begin
                    if (bkpt_match) begin
                        state_d    = S_IDLE;
                        bkpt_hit_d = 1'b1;
                    end else begin
                        fetch_en    = 1'b1;
                        state_d     = S_EXEC;
                        skip_bkpt_d = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                if (clk_en_pi) begin
                    if (load_pi || store_pi) begin
                        state_d    = S_MEM;
                        wait_cnt_d = 8'd0;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                // Runs on every clock, not the CPU tick; an ack in the timeout cycle still completes
                mem_req    = 1'b1;
                wait_cnt_d = wait_inc;
                if (mem_ack_pi) begin
                    state_d = S_WB;
                end else if (wait_inc == TIMEOUT_C) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                if (clk_en_pi) begin
                    commit        = 1'b1;
                    instr_count_d = instr_count_q + CNT_W'(1);
                    if (halt_cmd_pi) begin
                        state_d = S_HALT;
                    end else if (run_mode_pi) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_pi) begin
        step_prev_q <= step_pi;
        if (reset_pi) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
            bkpt_hit_q    <= 1'b0;
            step_pend_q   <= 1'b0;
            skip_bkpt_q   <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            bkpt_hit_q    <= bkpt_hit_d;
            step_pend_q   <= step_pend_d;
            skip_bkpt_q   <= skip_bkpt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign fetch_en_po    = fetch_en & ~reset_pi;
    assign commit_po      = commit & ~reset_pi;
    assign mem_req_po     = mem_req & ~reset_pi;
    assign halted_po      = (state_q == S_HALT);
    assign fault_po       = (state_q == S_FAULT);
    assign bkpt_hit_po    = bkpt_hit_q;
    assign state_po       = state_q;
    assign instr_count_po = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a per-cycle vector table followed by
// multi-cycle scenarios (free-run, memory ack/timeout, breakpoint, single-step, reset, wrap).
module tb_cpu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clk_en, run_mode, step, halt_cmd, load, store, mem_ack, bkpt_en;
    logic [15:0] pc, bkpt_addr;

    logic        fetch_en, commit, mem_req, halted, fault, bkpt_hit;
    logic [2:0]  state;
    logic [31:0] icount;

    logic        fetch_en4, commit4, mem_req4, halted4, fault4, bkpt_hit4;
    logic [2:0]  state4;
    logic [3:0]  icount4;

    cpu_sequencer dut (
        .clk_pi(clk), .reset_pi(reset), .clk_en_pi(clk_en), .run_mode_pi(run_mode),
        .step_pi(step), .halt_cmd_pi(halt_cmd), .load_pi(load), .store_pi(store),
        .mem_ack_pi(mem_ack), .pc_pi(pc), .bkpt_addr_pi(bkpt_addr), .bkpt_en_pi(bkpt_en),
        .fetch_en_po(fetch_en), .commit_po(commit), .mem_req_po(mem_req),
        .halted_po(halted), .fault_po(fault), .bkpt_hit_po(bkpt_hit),
        .state_po(state), .instr_count_po(icount)
    );

    cpu_sequencer #(.CNT_W(4)) dut4 (
        .clk_pi(clk), .reset_pi(reset), .clk_en_pi(clk_en), .run_mode_pi(run_mode),
        .step_pi(step), .halt_cmd_pi(halt_cmd), .load_pi(load), .store_pi(store),
        .mem_ack_pi(mem_ack), .pc_pi(pc), .bkpt_addr_pi(bkpt_addr), .bkpt_en_pi(bkpt_en),
        .fetch_en_po(fetch_en4), .commit_po(commit4), .mem_req_po(mem_req4),
        .halted_po(halted4), .fault_po(fault4), .bkpt_hit_po(bkpt_hit4),
        .state_po(state4), .instr_count_po(icount4)
    );

    // in = {rst, clk_en, run, step, halt, load, ack}; str = {fetch_en, commit, mem_req, halted}
    typedef struct packed {
        logic [6:0] in;
        logic [2:0] st;
        logic [3:0] str;
        logic [7:0] cnt;
    } vec_t;

    vec_t        tbl [20];
    int          checks = 0;
    int          failures = 0;
    int          n_fetch, n_commit, n_memreq;
    logic [2:0]  last_state;
    logic [2:0]  seq [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic one_cycle();
        logic f;
        @(negedge clk);
        f = fetch_en;
        if (fetch_en) n_fetch++;
        if (commit)   n_commit++;
        if (mem_req)  n_memreq++;
        @(posedge clk);
        #1;
        if (f) pc = pc + 16'd1;
        if (state !== last_state) begin
            seq.push_back(state);
            last_state = state;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; clk_en = 1'b0; run_mode = 1'b0; step = 1'b0; halt_cmd = 1'b0;
        load = 1'b0; store = 1'b0; mem_ack = 1'b0; bkpt_en = 1'b0;
        one_cycle();
        reset = 1'b0;
        pc = 16'd0; n_fetch = 0; n_commit = 0; n_memreq = 0;
        seq.delete();
        last_state = state;
    endtask

    task automatic run_until(input logic [2:0] s, input int maxc, input string nm);
        int k = 0;
        while (state !== s && k < maxc) begin
            one_cycle();
            k++;
        end
        check(nm, 64'(state), 64'(s));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [14:0] obs;
        logic [63:0] seq_act, seq_exp;
        logic [2:0]  exp_seq [13];

        reset = 1'b1; clk_en = 1'b0; run_mode = 1'b0; step = 1'b0; halt_cmd = 1'b0;
        load = 1'b0; store = 1'b0; mem_ack = 1'b0; bkpt_en = 1'b0;
        pc = 16'd0; bkpt_addr = 16'h0005;
        n_fetch = 0; n_commit = 0; n_memreq = 0; last_state = 3'd0;

        tbl[0]  = '{in: 7'b1110000, st: 3'd0, str: 4'b0000, cnt: 8'd0};
        tbl[1]  = '{in: 7'b0010000, st: 3'd0, str: 4'b0000, cnt: 8'd0};
        tbl[2]  = '{in: 7'b0110000, st: 3'd0, str: 4'b0000, cnt: 8'd0};
        tbl[3]  = '{in: 7'b0010000, st: 3'd1, str: 4'b0000, cnt: 8'd0};
        tbl[4]  = '{in: 7'b0110000, st: 3'd1, str: 4'b1000, cnt: 8'd0};
        tbl[5]  = '{in: 7'b0110010, st: 3'd2, str: 4'b0000, cnt: 8'd0};
        tbl[6]  = '{in: 7'b0010010, st: 3'd3, str: 4'b0010, cnt: 8'd0};
        tbl[7]  = '{in: 7'b0010011, st: 3'd3, str: 4'b0010, cnt: 8'd0};
        tbl[8]  = '{in: 7'b0000000, st: 3'd4, str: 4'b0000, cnt: 8'd0};
        tbl[9]  = '{in: 7'b0100000, st: 3'd4, str: 4'b0100, cnt: 8'd0};
        tbl[10] = '{in: 7'b0100000, st: 3'd0, str: 4'b0000, cnt: 8'd1};
        tbl[11] = '{in: 7'b0101000, st: 3'd0, str: 4'b0000, cnt: 8'd1};
        tbl[12] = '{in: 7'b0001000, st: 3'd0, str: 4'b0000, cnt: 8'd1};
        tbl[13] = '{in: 7'b0100000, st: 3'd0, str: 4'b0000, cnt: 8'd1};
        tbl[14] = '{in: 7'b0100000, st: 3'd1, str: 4'b1000, cnt: 8'd1};
        tbl[15] = '{in: 7'b0100100, st: 3'd2, str: 4'b0000, cnt: 8'd1};
        tbl[16] = '{in: 7'b0100100, st: 3'd4, str: 4'b0100, cnt: 8'd1};
        tbl[17] = '{in: 7'b0111000, st: 3'd5, str: 4'b0001, cnt: 8'd2};
        tbl[18] = '{in: 7'b1100000, st: 3'd5, str: 4'b0001, cnt: 8'd2};
        tbl[19] = '{in: 7'b0000000, st: 3'd0, str: 4'b0000, cnt: 8'd0};

        one_cycle();
        for (int i = 0; i < 20; i++) begin
            {reset, clk_en, run_mode, step, halt_cmd, load, mem_ack} = tbl[i].in;
            @(negedge clk);
            obs = {state, fetch_en, commit, mem_req, halted, icount[7:0]};
            check($sformatf("vec%0d", i), 64'(obs), 64'({tbl[i].st, tbl[i].str, tbl[i].cnt}));
            @(posedge clk);
            #1;
        end

        // Free-run, CPU tick every 4th clock, fourth instruction halts
        do_reset();
        run_mode = 1'b1;
        for (int i = 0; i < 200 && state !== 3'd5; i++) begin
            clk_en   = (i % 4 == 3);
            halt_cmd = (n_fetch >= 4);
            one_cycle();
        end
        exp_seq = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd5};
        seq_act = '0;
        seq_exp = '0;
        foreach (seq[j]) seq_act = (seq_act << 3) | 64'(seq[j]);
        foreach (exp_seq[j]) seq_exp = (seq_exp << 3) | 64'(exp_seq[j]);
        check("fr_seq_len", 64'(seq.size()), 64'(13));
        check("fr_seq", seq_act, seq_exp);
        check("fr_state", 64'(state), 64'(5));
        check("fr_halted", 64'(halted), 64'(1));
        check("fr_commits", 64'(n_commit), 64'(4));
        check("fr_fetches", 64'(n_fetch), 64'(4));
        check("fr_count", 64'(icount), 64'(4));

        // Load acked in the third MEM cycle
        do_reset();
        run_mode = 1'b1; load = 1'b1; clk_en = 1'b1; halt_cmd = 1'b1;
        run_until(3'd3, 10, "ld_reach_mem");
        for (int k = 1; k <= 3; k++) begin
            mem_ack = (k == 3);
            one_cycle();
        end
        mem_ack = 1'b0;
        check("ld_memreq_cycles", 64'(n_memreq), 64'(3));
        check("ld_state_wb", 64'(state), 64'(4));
        one_cycle();
        check("ld_commits", 64'(n_commit), 64'(1));
        check("ld_count", 64'(icount), 64'(1));
        check("ld_state_halt", 64'(state), 64'(5));

        // Ack on the timeout cycle still completes
        do_reset();
        run_mode = 1'b1; load = 1'b1; clk_en = 1'b1; halt_cmd = 1'b1;
        run_until(3'd3, 10, "ldto_reach_mem");
        for (int k = 1; k <= 15; k++) begin
            mem_ack = (k == 15);
            one_cycle();
        end
        mem_ack = 1'b0;
        check("ldto_memreq_cycles", 64'(n_memreq), 64'(15));
        check("ldto_state_wb", 64'(state), 64'(4));
        check("ldto_no_fault", 64'(fault), 64'(0));

        // Store with no ack times out
        do_reset();
        run_mode = 1'b1; store = 1'b1; clk_en = 1'b1;
        run_until(3'd3, 10, "st_reach_mem");
        for (int k = 1; k <= 14; k++) one_cycle();
        check("st_still_mem", 64'(state), 64'(3));
        one_cycle();
        check("st_state_fault", 64'(state), 64'(6));
        check("st_fault_flag", 64'(fault), 64'(1));
        check("st_memreq_cycles", 64'(n_memreq), 64'(15));
        for (int k = 0; k < 6; k++) begin
            step = k[0];
            one_cycle();
        end
        step = 1'b0;
        check("st_fault_holds", 64'(state), 64'(6));
        check("st_no_commit", 64'(n_commit), 64'(0));
        check("st_no_refetch", 64'(n_fetch), 64'(1));

        // Breakpoint at pc 5, then one step, then free-run resumes
        do_reset();
        bkpt_addr = 16'h0005; bkpt_en = 1'b1; run_mode = 1'b1; clk_en = 1'b1;
        for (int i = 0; i < 60 && bkpt_hit !== 1'b1; i++) one_cycle();
        check("bk_hit", 64'(bkpt_hit), 64'(1));
        check("bk_state_idle", 64'(state), 64'(0));
        check("bk_pc", 64'(pc), 64'(5));
        check("bk_fetches", 64'(n_fetch), 64'(5));
        check("bk_commits", 64'(n_commit), 64'(5));
        for (int k = 0; k < 4; k++) one_cycle();
        check("bk_hold_state", 64'(state), 64'(0));
        check("bk_hold_nofetch", 64'(n_fetch), 64'(5));
        step = 1'b1;
        one_cycle();
        step = 1'b0;
        for (int i = 0; i < 40 && n_commit < 8; i++) one_cycle();
        check("bk_resume_commits", 64'(n_commit), 64'(8));
        check("bk_resume_fetches", 64'(n_fetch), 64'(8));
        check("bk_cleared", 64'(bkpt_hit), 64'(0));
        check("bk_resume_pc", 64'(pc), 64'(8));
        bkpt_en = 1'b0;

        // Single-step, with an ignored step edge during EXEC
        do_reset();
        run_mode = 1'b0; clk_en = 1'b1;
        for (int k = 0; k < 3; k++) one_cycle();
        check("ss_idle_wait", 64'(n_fetch), 64'(0));
        step = 1'b1;
        one_cycle();
        step = 1'b0;
        for (int i = 0; i < 10 && n_commit < 1; i++) one_cycle();
        check("ss1_commits", 64'(n_commit), 64'(1));
        check("ss1_idle", 64'(state), 64'(0));
        step = 1'b1;
        one_cycle();
        step = 1'b0;
        run_until(3'd2, 10, "ss2_exec");
        step = 1'b1;
        one_cycle();
        step = 1'b0;
        for (int i = 0; i < 10 && n_commit < 2; i++) one_cycle();
        check("ss2_idle", 64'(state), 64'(0));
        for (int k = 0; k < 6; k++) one_cycle();
        check("ss_total_commits", 64'(n_commit), 64'(2));
        check("ss_total_fetches", 64'(n_fetch), 64'(2));
        check("ss_final_state", 64'(state), 64'(0));

        // Reset while a load waits in MEM
        do_reset();
        run_mode = 1'b1; load = 1'b1; mem_ack = 1'b1; clk_en = 1'b1;
        for (int i = 0; i < 30 && n_commit < 2; i++) one_cycle();
        mem_ack = 1'b0;
        run_until(3'd3, 10, "rm_reach_mem");
        one_cycle();
        check("rm_memreq_before", 64'(mem_req), 64'(1));
        check("rm_count_before", 64'(icount), 64'(2));
        reset = 1'b1;
        one_cycle();
        reset = 1'b0;
        check("rm_state", 64'(state), 64'(0));
        check("rm_memreq", 64'(mem_req), 64'(0));
        check("rm_count", 64'(icount), 64'(0));

        // 16 retirements wrap a 4-bit counter
        do_reset();
        run_mode = 1'b1; clk_en = 1'b1;
        for (int i = 0; i < 100 && n_commit < 16; i++) one_cycle();
        check("wrap_commits", 64'(n_commit), 64'(16));
        check("wrap_count32", 64'(icount), 64'(16));
        check("wrap_count4", 64'(icount4), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
